// File: rtl/mac_pkg.sv
// Shared definitions for the MAC batch driver.
// Holds the element/batch geometry, the driver FSM state type and the
// lane element type used by the top module and its lane register files.
package mac_pkg;

    // Bits per unsigned operand element.
    localparam int unsigned SIZE  = 6;
    // Operand sets packed into one MAC batch.
    localparam int unsigned SETS  = 16;
    // Result width; matches the MAC out port.
    localparam int unsigned OUT_W = (SIZE << 1) + SETS;
    // Lane index width.
    localparam int unsigned CNT_W = $clog2(SETS);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ISSUE  = 2'd1,
        RESULT = 2'd2
    } mac_drv_state_t;

    typedef logic [SIZE-1:0] mac_elem_t;

endpackage

// File: rtl/mac_lane_reg.sv
// SETS x SIZE register file with a single indexed write port.
// Every lane is visible at once on a packed output, lane k occupying
// bits [(k+1)*SIZE-1 : k*SIZE].
// Ports:
//   clk    in   1           clock, rising edge
//   reset  in   1           synchronous active-high reset, clears all lanes
//   we     in   1           write enable
//   idx    in   CNT_W       lane written when we is high
//   din    in   SIZE        element written into lane idx
//   dout   out  SETS*SIZE   all lanes, packed
module mac_lane_reg
    import mac_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [CNT_W-1:0]     idx,
    input  logic [SIZE-1:0]      din,
    output logic [SETS*SIZE-1:0] dout
);

    mac_elem_t lanes_q [SETS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SETS; i++) begin
                lanes_q[i] <= '0;
            end
        end else if (we) begin
            lanes_q[idx] <= din;
        end
    end

    for (genvar g = 0; g < SETS; g++) begin : g_pack
        assign dout[g*SIZE +: SIZE] = lanes_q[g];
    end

endmodule

// File: rtl/mac_batch_driver.sv
// Initiator side of the MAC valid/ready operand interface.
// Collects SETS (a,b,c) operand sets from an upstream valid/ready stream,
// presents the packed batch to the dot-product MAC with mac_valid, captures
// the MAC sum when mac_ready is seen and holds it on a valid/ready result
// port until downstream takes it.  FSM: LOAD -> ISSUE -> RESULT -> LOAD.
// Ports:
//   clk        in   1          clock, all state on rising edge
//   reset      in   1          synchronous active-high reset
//   op_valid   in   1          upstream operand set valid
//   op_ready   out  1          operand set accepted this cycle (LOAD only)
//   op_a/b/c   in   SIZE       operand elements
//   mac_valid  out  1          packed batch presented to the MAC (ISSUE)
//   mac_ready  in   1          MAC result available on mac_out
//   mac_a/b/c  out  SETS*SIZE  packed operand vectors
//   mac_out    in   OUT_W      MAC result
//   res_valid  out  1          captured result held (RESULT)
//   res_ready  in   1          downstream accepts result
//   res_data   out  OUT_W      captured MAC result
//   busy       out  1          not idle: outside LOAD or a partial batch held
module mac_batch_driver
    import mac_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [SIZE-1:0]      op_a,
    input  logic [SIZE-1:0]      op_b,
    input  logic [SIZE-1:0]      op_c,
    output logic                 mac_valid,
    input  logic                 mac_ready,
    output logic [SETS*SIZE-1:0] mac_a,
    output logic [SETS*SIZE-1:0] mac_b,
    output logic [SETS*SIZE-1:0] mac_c,
    input  logic [OUT_W-1:0]     mac_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OUT_W-1:0]     res_data,
    output logic                 busy
);

    localparam logic [1:0] ST_LOAD   = LOAD;
    localparam logic [1:0] ST_ISSUE  = ISSUE;
    localparam logic [1:0] ST_RESULT = RESULT;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SETS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OUT_W-1:0] res_data_q, res_data_d;
    logic             op_fire;

    assign op_ready  = (state_q == ST_LOAD);
    assign mac_valid = (state_q == ST_ISSUE);
    assign res_valid = (state_q == ST_RESULT);
    assign res_data  = res_data_q;
    assign busy      = (state_q != ST_LOAD) || (count_q != '0);

    assign op_fire = op_valid && op_ready;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        res_data_d = res_data_q;
        case (state_q)
            ST_LOAD: begin
                if (op_fire) begin
                    // Explicit wrap so a non-power-of-two SETS behaves the same.
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (mac_ready) begin
                    res_data_d = mac_out;
                    state_d    = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            count_q    <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            res_data_q <= res_data_d;
        end
    end

    // Lanes are only written in LOAD; they are never cleared between batches
    // because a full batch overwrites every lane.
    mac_lane_reg u_lane_a (
        .clk   (clk),
        .reset (reset),
        .we    (op_fire),
        .idx   (count_q),
        .din   (op_a),
        .dout  (mac_a)
    );

    mac_lane_reg u_lane_b (
        .clk   (clk),
        .reset (reset),
        .we    (op_fire),
        .idx   (count_q),
        .din   (op_b),
        .dout  (mac_b)
    );

    mac_lane_reg u_lane_c (
        .clk   (clk),
        .reset (reset),
        .we    (op_fire),
        .idx   (count_q),
        .din   (op_c),
        .dout  (mac_c)
    );

endmodule

// File: tb/tb_mac_batch_driver.sv
// Directed and randomized bench for mac_batch_driver.  A behavioural MAC
// answers the driver; expected results are computed from the operand sets
// the bench itself sent.
module tb_mac_batch_driver;
    import mac_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 op_valid;
    logic                 op_ready;
    logic [SIZE-1:0]      op_a, op_b, op_c;
    logic                 mac_valid;
    logic                 mac_ready;
    logic [SETS*SIZE-1:0] mac_a, mac_b, mac_c;
    logic [OUT_W-1:0]     mac_out;
    logic                 res_valid;
    logic                 res_ready;
    logic [OUT_W-1:0]     res_data;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    // Operand sets of the batch currently being sent.
    int ta [SETS];
    int tbv[SETS];
    int tc [SETS];

    mac_batch_driver dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .mac_valid (mac_valid),
        .mac_ready (mac_ready),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_out   (mac_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: sum over k of a_k*b_k + c_k.
    always_comb begin
        logic [OUT_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < SETS; k++) begin
            acc = acc + OUT_W'(mac_a[k*SIZE +: SIZE]) * OUT_W'(mac_b[k*SIZE +: SIZE])
                      + OUT_W'(mac_c[k*SIZE +: SIZE]);
        end
        mac_out = acc;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " op_ready"}, 128'(op_ready), 128'(1));
        check({tag, " mac_valid"}, 128'(mac_valid), 128'(0));
        check({tag, " res_valid"}, 128'(res_valid), 128'(0));
        check({tag, " res_data"}, 128'(res_data), 128'(0));
        check({tag, " busy"}, 128'(busy), 128'(0));
        check({tag, " mac_a"}, 128'(mac_a), 128'(0));
        check({tag, " mac_b"}, 128'(mac_b), 128'(0));
        check({tag, " mac_c"}, 128'(mac_c), 128'(0));
    endtask

    // Send sets 0..n-1 of ta/tbv/tc. mode 0: continuous, 1: valid low on even
    // cycles, 2: random gaps. Returns the number of cycles spent.
    task automatic feed(input string tag, input int n, input int mode, output int cycles);
        int idx;
        logic acc_now;
        idx    = 0;
        cycles = 0;
        while (idx < n && cycles < 400) begin
            case (mode)
                0:       op_valid = 1'b1;
                1:       op_valid = (cycles % 2) == 1;
                default: op_valid = ($urandom_range(0, 2) != 0);
            endcase
            if (op_valid) begin
                op_a = SIZE'(ta[idx]);
                op_b = SIZE'(tbv[idx]);
                op_c = SIZE'(tc[idx]);
            end else begin
                op_a = SIZE'($urandom);
                op_b = SIZE'($urandom);
                op_c = SIZE'($urandom);
            end
            acc_now = op_valid && op_ready;
            step();
            if (acc_now) idx++;
            cycles++;
        end
        op_valid = 1'b0;
        check({tag, " sets accepted"}, 128'(idx), 128'(n));
    endtask

    task automatic expected(output logic [SETS*SIZE-1:0] ea, output logic [SETS*SIZE-1:0] eb,
                            output logic [SETS*SIZE-1:0] ec, output int sum);
        sum = 0;
        for (int k = 0; k < SETS; k++) begin
            ea[k*SIZE +: SIZE] = SIZE'(ta[k]);
            eb[k*SIZE +: SIZE] = SIZE'(tbv[k]);
            ec[k*SIZE +: SIZE] = SIZE'(tc[k]);
            sum += ta[k] * tbv[k] + tc[k];
        end
    endtask

    // Called in the first ISSUE cycle with mac_ready already high.
    task automatic finish_batch(input string tag);
        logic [SETS*SIZE-1:0] ea, eb, ec;
        int sum;
        expected(ea, eb, ec, sum);
        check({tag, " mac_valid"}, 128'(mac_valid), 128'(1));
        check({tag, " res_valid early"}, 128'(res_valid), 128'(0));
        check({tag, " mac_a"}, 128'(mac_a), 128'(ea));
        check({tag, " mac_b"}, 128'(mac_b), 128'(eb));
        check({tag, " mac_c"}, 128'(mac_c), 128'(ec));
        step();
        check({tag, " res_valid"}, 128'(res_valid), 128'(1));
        check({tag, " res_data"}, 128'(res_data), 128'(sum));
        check({tag, " op_ready in RESULT"}, 128'(op_ready), 128'(0));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, " res_valid after"}, 128'(res_valid), 128'(0));
        check({tag, " op_ready after"}, 128'(op_ready), 128'(1));
        check({tag, " busy after"}, 128'(busy), 128'(0));
    endtask

    initial begin
        int cyc;
        logic [SETS*SIZE-1:0] ea, eb, ec;
        int sum;

        reset     = 1'b1;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_c      = '0;
        mac_ready = 1'b1;
        res_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_reset_state("reset");

        // 1: all ones, continuous -> 32, mac_valid N+1, res_valid N+2.
        for (int k = 0; k < SETS; k++) begin ta[k] = 1; tbv[k] = 1; tc[k] = 1; end
        feed("t1", SETS, 0, cyc);
        check("t1 cycles", 128'(cyc), 128'(SETS));
        finish_batch("t1");

        // 2: all max -> 64512.
        for (int k = 0; k < SETS; k++) begin ta[k] = 63; tbv[k] = 63; tc[k] = 63; end
        feed("t2", SETS, 0, cyc);
        finish_batch("t2");

        // 3: a_k=k, b=1, c=0 with op_valid toggling -> 120 over 32 cycles.
        for (int k = 0; k < SETS; k++) begin ta[k] = k; tbv[k] = 1; tc[k] = 0; end
        feed("t3", SETS, 1, cyc);
        check("t3 cycles", 128'(cyc), 128'(2 * SETS));
        finish_batch("t3");

        // Random operands with random gaps.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < SETS; k++) begin
                ta[k]  = int'($urandom_range(0, 63));
                tbv[k] = int'($urandom_range(0, 63));
                tc[k]  = int'($urandom_range(0, 63));
            end
            feed("rnd", SETS, 2, cyc);
            finish_batch("rnd");
        end

        // 4: mac_ready low for 5 ISSUE cycles, junk op_valid ignored.
        for (int k = 0; k < SETS; k++) begin
            ta[k]  = int'($urandom_range(0, 63));
            tbv[k] = int'($urandom_range(0, 63));
            tc[k]  = int'($urandom_range(0, 63));
        end
        mac_ready = 1'b0;
        feed("t4", SETS, 0, cyc);
        expected(ea, eb, ec, sum);
        for (int i = 0; i < 5; i++) begin
            op_valid = 1'b1;
            op_a = SIZE'($urandom);
            op_b = SIZE'($urandom);
            op_c = SIZE'($urandom);
            check("t4 mac_valid hold", 128'(mac_valid), 128'(1));
            check("t4 op_ready low", 128'(op_ready), 128'(0));
            check("t4 mac_a hold", 128'(mac_a), 128'(ea));
            check("t4 mac_b hold", 128'(mac_b), 128'(eb));
            check("t4 mac_c hold", 128'(mac_c), 128'(ec));
            check("t4 res_valid low", 128'(res_valid), 128'(0));
            step();
        end
        op_valid  = 1'b0;
        mac_ready = 1'b1;
        finish_batch("t4");

        // 5: res_ready low for 4 cycles with op_valid pending.
        for (int k = 0; k < SETS; k++) begin
            ta[k]  = int'($urandom_range(0, 63));
            tbv[k] = int'($urandom_range(0, 63));
            tc[k]  = int'($urandom_range(0, 63));
        end
        feed("t5", SETS, 0, cyc);
        expected(ea, eb, ec, sum);
        check("t5 mac_valid", 128'(mac_valid), 128'(1));
        step();
        op_valid = 1'b1;
        op_a = 6'd5;
        op_b = 6'd7;
        op_c = 6'd9;
        for (int i = 0; i < 4; i++) begin
            check("t5 res_valid hold", 128'(res_valid), 128'(1));
            check("t5 res_data hold", 128'(res_data), 128'(sum));
            check("t5 op_ready low", 128'(op_ready), 128'(0));
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t5 nothing consumed", 128'(busy), 128'(0));
        check("t5 op_ready back", 128'(op_ready), 128'(1));
        step();
        op_valid = 1'b0;
        check("t5 op consumed after handshake", 128'(busy), 128'(1));

        // 6: 7 sets loaded in total, reset, then a=2,b=3,c=0 -> 96.
        for (int k = 0; k < SETS; k++) begin
            ta[k]  = int'($urandom_range(1, 63));
            tbv[k] = int'($urandom_range(1, 63));
            tc[k]  = int'($urandom_range(1, 63));
        end
        feed("t6 partial", 6, 0, cyc);
        check("t6 busy partial", 128'(busy), 128'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state("t6 reset");
        for (int k = 0; k < SETS; k++) begin ta[k] = 2; tbv[k] = 3; tc[k] = 0; end
        feed("t6", SETS, 0, cyc);
        finish_batch("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
